// File: rtl/pll_lock_rst_seq.sv
// PLL lock qualifier and core/peripheral reset release sequencer on the free-running refclk.
// Optional lock timeout watchdog is built only when PLL_LOCK_TIMEOUT_EN is defined.
module pll_lock_rst_seq #(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int PERIPH_DELAY       = 8
`ifdef PLL_LOCK_TIMEOUT_EN
  ,
  parameter int LOCK_TIMEOUT       = 50000
`endif
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       pll_extlock,
  input  logic       clr_status,
  output logic       core_rst_n,
  output logic       periph_rst_n,
  output logic       pll_ready,
  output logic       lock_lost,
  output logic [7:0] lock_loss_cnt,
  output logic       lock_timeout,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_e;

  localparam int SW = (LOCK_STABLE_CYCLES > 2) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int DW = (PERIPH_DELAY > 1) ? $clog2(PERIPH_DELAY + 1) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DLY_MAX   = DW'(PERIPH_DELAY);

  logic          sync1_q, sync2_q;
  logic          lock_s;
  state_e        state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          core_q, core_d;
  logic          periph_q, periph_d;
  logic          lost_q, lost_d;
  logic [7:0]    cnt_q, cnt_d;

  assign lock_s = sync2_q;

  // Handshake-free block: pll_extlock is a level, only its synchronized copy lock_s is consumed.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_extlock;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    dly_d   = dly_q;
    lost_d  = lost_q;
    cnt_d   = cnt_q;
    if (clr_status) begin
      lost_d = 1'b0;
      cnt_d  = 8'd0;
    end
    case (state_q)
      WAIT_LOCK: begin
        stab_d = '0;
        dly_d  = '0;
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = RUN;
          dly_d   = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      RUN: begin
        // Loss of lock takes priority over the peripheral delay count.
        if (!lock_s) begin
          state_d = LOST;
          lost_d  = 1'b1;
          if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
        end else if (dly_q != DLY_MAX) begin
          dly_d = dly_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        stab_d  = '0;
        dly_d   = '0;
      end
    endcase
    // Reset outputs are registered from the next state so they move on the transition edge.
    core_d   = (state_d == RUN);
    periph_d = (state_d == RUN) && (dly_d == DLY_MAX);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= WAIT_LOCK;
      stab_q   <= '0;
      dly_q    <= '0;
      core_q   <= 1'b0;
      periph_q <= 1'b0;
      lost_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      stab_q   <= stab_d;
      dly_q    <= dly_d;
      core_q   <= core_d;
      periph_q <= periph_d;
      lost_q   <= lost_d;
      cnt_q    <= cnt_d;
    end
  end

  assign core_rst_n    = core_q;
  assign periph_rst_n  = periph_q;
  assign pll_ready     = periph_q;
  assign lock_lost     = lost_q;
  assign lock_loss_cnt = cnt_q;
  assign dbg_state     = state_q;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic [15:0] TO_MAX = 16'(LOCK_TIMEOUT);

  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;

  // Counts time spent trying to lock; restarts only after reset or a lock loss.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == LOST) begin
      to_cnt_d = 16'd0;
    end else if ((state_q != RUN) && (to_cnt_q != TO_MAX)) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
    timeout_d = timeout_q | (to_cnt_d == TO_MAX);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign lock_timeout = timeout_q;
`else
  assign lock_timeout = 1'b0;
`endif

endmodule
